// File: rtl/dot_product_pkg.sv
// Shared width helpers and saturation bounds for the dot-product datapath.
// Bounds are held in 64-bit signed form, so OUT_WIDTH and ACC_W must stay below 63.
package dot_product_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  // One guard bit for subtraction, plus log2(N) bits of growth so the sum never wraps.
  function automatic int unsigned acc_width(input int unsigned a_w, input int unsigned b_w,
                                            input int unsigned n_terms);
    return prod_width(a_w, b_w) + 1 + clog2(n_terms);
  endfunction

  function automatic logic signed [63:0] sat_hi(input int unsigned out_w, input bit out_signed);
    return out_signed ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int unsigned out_w, input bit out_signed);
    return out_signed ? -(64'sd1 <<< (out_w - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/dot_product_pipe_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp with an overflow flag.
// Shared by colour-path blocks that narrow a wide signed accumulator.
module round_sat
  import dot_product_pkg::*;
#(
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned OUT_WIDTH  = 20,
  parameter bit          OUT_SIGNED = 1'b1
) (
  input  logic [ACC_W-1:0]     sum_i,
  output logic [OUT_WIDTH-1:0] y_o,
  output logic                 ovf_o
);

  localparam int unsigned      HalfPos = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [ACC_W:0]   Half    = (SHIFT == 0) ? '0 : ((ACC_W + 1)'(1) << HalfPos);
  localparam logic signed [63:0] SatHi = sat_hi(OUT_WIDTH, OUT_SIGNED);
  localparam logic signed [63:0] SatLo = sat_lo(OUT_WIDTH, OUT_SIGNED);

  logic [ACC_W:0]        rnd;
  logic signed [ACC_W:0] shifted;
  logic signed [63:0]    r_ext;

  always_comb begin
    // One extra bit so adding the half-LSB cannot wrap.
    rnd     = {sum_i[ACC_W-1], sum_i} + Half;
    shifted = $signed(rnd) >>> SHIFT;
    r_ext   = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};
    y_o     = r_ext[OUT_WIDTH-1:0];
    ovf_o   = 1'b0;
    if (r_ext > SatHi) begin
      y_o   = SatHi[OUT_WIDTH-1:0];
      ovf_o = 1'b1;
    end else if (r_ext < SatLo) begin
      y_o   = SatLo[OUT_WIDTH-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/dot_product_pipe.sv
// Three-stage pipelined N-term dot product with per-term add/subtract, valid/ready
// handshake, rounding shift and output saturation.
module dot_product_pipe
  import dot_product_pkg::*;
#(
  parameter int unsigned N_TERMS    = 3,
  parameter int unsigned A_WIDTH    = 8,
  parameter int unsigned B_WIDTH    = 9,
  parameter bit          A_SIGNED   = 1'b0,
  parameter bit          B_SIGNED   = 1'b1,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned OUT_WIDTH  = 20,
  parameter bit          OUT_SIGNED = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_TERMS*A_WIDTH-1:0]   a,
  input  logic [N_TERMS*B_WIDTH-1:0]   b,
  input  logic [N_TERMS-1:0]           sub_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         y,
  output logic                         overflow
);

  localparam int unsigned PW    = prod_width(A_WIDTH, B_WIDTH);
  localparam int unsigned MW    = PW + 1;
  localparam int unsigned ACC_W = acc_width(A_WIDTH, B_WIDTH, N_TERMS);
  localparam bit          ProdSigned = A_SIGNED || B_SIGNED;

  logic                 en;
  logic                 v1_d, v1_q, v2_d, v2_q, ov_d, ov_q;
  logic [N_TERMS-1:0]   mask_d, mask_q;
  logic [ACC_W-1:0]     partial [N_TERMS+1];
  logic [ACC_W-1:0]     sum_d, sum_q;
  logic [OUT_WIDTH-1:0] y_d, y_q;
  logic                 ovf_d, ovf_q;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign en       = !ov_q || out_ready;
  assign in_ready = en;

  assign partial[0] = '0;

  for (genvar i = 0; i < N_TERMS; i++) begin : g_term
    logic signed [MW-1:0] a_ext, b_ext;
    logic [PW-1:0]        prod_d, prod_q;
    logic [ACC_W-1:0]     term;

    // Unsigned operands gain a zero MSB so one signed multiplier covers every mix.
    always_comb begin
      a_ext  = {{(MW - A_WIDTH){A_SIGNED & a[i*A_WIDTH + A_WIDTH - 1]}}, a[i*A_WIDTH +: A_WIDTH]};
      b_ext  = {{(MW - B_WIDTH){B_SIGNED & b[i*B_WIDTH + B_WIDTH - 1]}}, b[i*B_WIDTH +: B_WIDTH]};
      prod_d = PW'(a_ext * b_ext);
      term   = {{(ACC_W - PW){ProdSigned & prod_q[PW-1]}}, prod_q};
    end

    always_ff @(posedge clk) begin
      if (en) begin
        prod_q <= prod_d;
      end
    end

    assign partial[i+1] = mask_q[i] ? partial[i] - term : partial[i] + term;
  end

  always_comb begin
    v1_d   = in_valid;
    mask_d = sub_mask;
    v2_d   = v1_q;
    sum_d  = partial[N_TERMS];
    ov_d   = v2_q;
  end

  round_sat #(
    .ACC_W      (ACC_W),
    .SHIFT      (SHIFT),
    .OUT_WIDTH  (OUT_WIDTH),
    .OUT_SIGNED (OUT_SIGNED)
  ) u_round_sat (
    .sum_i (sum_q),
    .y_o   (y_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v1_q   <= v1_d;
      mask_q <= mask_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      ov_q   <= ov_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_pipe.sv
// Bench for dot_product_pipe: six configurations share one stimulus stream and are
// checked in lockstep against an integer reference model through a scoreboard queue.
module tb_dot_product_pipe;

  localparam int NCFG = 6;
  localparam int unsigned CN  [NCFG] = '{3, 3, 3, 4, 1, 3};
  localparam bit          CAS [NCFG] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit          CBS [NCFG] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam int unsigned CSH [NCFG] = '{0, 8, 8, 3, 2, 4};
  localparam int unsigned COW [NCFG] = '{20, 20, 8, 14, 15, 12};
  localparam bit          COS [NCFG] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  typedef struct packed {
    logic [NCFG-1:0][63:0] y;
    logic [NCFG-1:0]       o;
  } exp_t;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic [31:0] a_all;
  logic [35:0] b_all;
  logic [3:0]  mask_all;
  logic [NCFG-1:0]       ir_v, ov_v, ovf_v;
  logic [NCFG-1:0][63:0] yv;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned N  = CN[g];
    localparam int unsigned OW = COW[g];
    logic [OW-1:0] y;
    logic          ovf, ov, ir;

    dot_product_pipe #(
      .N_TERMS    (N),
      .A_WIDTH    (8),
      .B_WIDTH    (9),
      .A_SIGNED   (CAS[g]),
      .B_SIGNED   (CBS[g]),
      .SHIFT      (CSH[g]),
      .OUT_WIDTH  (OW),
      .OUT_SIGNED (COS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (ir),
      .a         (a_all[N*8-1:0]),
      .b         (b_all[N*9-1:0]),
      .sub_mask  (mask_all[N-1:0]),
      .out_valid (ov),
      .out_ready (out_ready),
      .y         (y),
      .overflow  (ovf)
    );

    assign yv[g]    = {{(64 - OW){COS[g] & y[OW-1]}}, y};
    assign ov_v[g]  = ov;
    assign ir_v[g]  = ir;
    assign ovf_v[g] = ovf;
  end

  int     total = 0;
  int     bad   = 0;
  exp_t   q[$];
  bit     accepted, got;
  int     npop = 0;
  longint ly [NCFG];
  bit     lo [NCFG];
  bit     hold [NCFG];
  longint py [NCFG];
  bit     po [NCFG];

  task automatic chk(input string tag, input longint observed, input longint expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] pa(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  function automatic logic [35:0] pb(input int x0, input int x1, input int x2, input int x3);
    return {x3[8:0], x2[8:0], x1[8:0], x0[8:0]};
  endfunction

  // Reference: plain integer arithmetic, floor division for the shift, explicit clamp.
  function automatic void model(input int c, input logic [31:0] av, input logic [35:0] bv,
                                input logic [3:0] mv, output longint yo, output bit oo);
    longint s, ai, bi, r, hi, lo_b;
    logic [7:0] ab;
    logic [8:0] bb;
    s = 0;
    for (int i = 0; i < int'(CN[c]); i++) begin
      ab = av[i*8 +: 8];
      bb = bv[i*9 +: 9];
      ai = (CAS[c] && ab[7]) ? longint'(ab) - 256 : longint'(ab);
      bi = (CBS[c] && bb[8]) ? longint'(bb) - 512 : longint'(bb);
      if (mv[i]) s = s - ai * bi;
      else       s = s + ai * bi;
    end
    if (CSH[c] > 0) begin
      r = s + (longint'(1) << (CSH[c] - 1));
      r = r >>> CSH[c];
    end else begin
      r = s;
    end
    hi   = COS[c] ? (longint'(1) << (COW[c] - 1)) - 1 : (longint'(1) << COW[c]) - 1;
    lo_b = COS[c] ? -(longint'(1) << (COW[c] - 1)) : 0;
    oo = 1'b0;
    yo = r;
    if (r > hi) begin
      yo = hi;
      oo = 1'b1;
    end else if (r < lo_b) begin
      yo = lo_b;
      oo = 1'b1;
    end
  endfunction

  // One clock: sample at negedge, pop/compare on output, push on accept, then edge.
  task automatic step();
    exp_t   e;
    longint my;
    bit     mo;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      if (hold[c]) begin
        chk($sformatf("hold_valid cfg%0d", c), longint'(ov_v[c]), 1);
        chk($sformatf("hold_y cfg%0d", c), longint'(yv[c]), py[c]);
        chk($sformatf("hold_ovf cfg%0d", c), longint'(ovf_v[c]), longint'(po[c]));
      end
    end
    if (ov_v[0] && !out_ready) chk("in_ready_stall", longint'(ir_v[0]), 0);
    got = 1'b0;
    if ((|ov_v) && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", longint'(ov_v), 0);
      end else begin
        e = q.pop_front();
        got = 1'b1;
        npop++;
        for (int c = 0; c < NCFG; c++) begin
          chk($sformatf("out_valid cfg%0d", c), longint'(ov_v[c]), 1);
          chk($sformatf("y cfg%0d", c), longint'(yv[c]), longint'(e.y[c]));
          chk($sformatf("ovf cfg%0d", c), longint'(ovf_v[c]), longint'(e.o[c]));
          ly[c] = longint'(yv[c]);
          lo[c] = ovf_v[c];
        end
      end
    end
    accepted = in_valid && ir_v[0];
    if (accepted) begin
      for (int c = 0; c < NCFG; c++) begin
        model(c, a_all, b_all, mask_all, my, mo);
        e.y[c] = my;
        e.o[c] = mo;
      end
      q.push_back(e);
    end
    for (int c = 0; c < NCFG; c++) begin
      hold[c] = ov_v[c] && !out_ready;
      py[c]   = longint'(yv[c]);
      po[c]   = ovf_v[c];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input logic [31:0] av, input logic [35:0] bv, input logic [3:0] mv);
    int lat;
    a_all = av;
    b_all = bv;
    mask_all = mv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      lat++;
      step();
    end
    chk("latency", lat, 3);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 12 && q.size() > 0; k++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("%s out_valid cfg%0d", tag, c), longint'(ov_v[c]), 0);
      chk($sformatf("%s in_ready cfg%0d", tag, c), longint'(ir_v[c]), 1);
      chk($sformatf("%s y cfg%0d", tag, c), longint'(yv[c]), 0);
      chk($sformatf("%s ovf cfg%0d", tag, c), longint'(ovf_v[c]), 0);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va [6];
    logic [35:0] vb [6];
    logic [3:0]  vm [6];
    int idx, p0, nacc;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_all = '0;
    b_all = '0;
    mask_all = '0;
    for (int c = 0; c < NCFG; c++) hold[c] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results
    run_single(pa(100, 50, 20, 0), pb(200, -10, 30, 0), 4'b0110);
    chk("dir_mix y0", ly[0], 19900);
    chk("dir_mix ovf0", longint'(lo[0]), 0);
    chk("dir_mix shift8 y1", ly[1], 78);
    run_single(pa(100, 50, 20, 0), pb(200, -10, 30, 0), 4'b0000);
    chk("dir_add y0", ly[0], 20100);
    run_single(pa(100, 50, 20, 0), pb(200, -10, 30, 0), 4'b0111);
    chk("dir_neg y0", ly[0], -20100);
    run_single(pa(1, 0, 0, 0), pb(-128, 0, 0, 0), 4'b0000);
    chk("tie_up y1", ly[1], 0);
    chk("tie_up y0", ly[0], -128);
    run_single(pa(1, 0, 0, 0), pb(-129, 0, 0, 0), 4'b0000);
    chk("below_tie y1", ly[1], -1);
    run_single(pa(255, 0, 0, 0), pb(-256, 0, 0, 0), 4'b0000);
    chk("clamp_lo y2", ly[2], 0);
    chk("clamp_lo ovf2", longint'(lo[2]), 1);
    run_single(pa(255, 255, 0, 0), pb(255, 255, 0, 0), 4'b0000);
    chk("clamp_hi y2", ly[2], 255);
    chk("clamp_hi ovf2", longint'(lo[2]), 1);
    chk("single_term y4", ly[4], 16256);
    chk("single_term ovf4", longint'(lo[4]), 0);

    // Back-to-back stream with downstream stalled in cycles 4..8
    for (int i = 0; i < 6; i++) begin
      va[i] = $urandom();
      vb[i] = 36'({$urandom(), $urandom()});
      vm[i] = 4'($urandom());
    end
    p0 = npop;
    idx = 0;
    for (int k = 0; k < 40; k++) begin
      if (idx >= 6 && q.size() == 0) break;
      out_ready = !(k >= 4 && k <= 8);
      in_valid = (idx < 6);
      if (idx < 6) begin
        a_all = va[idx];
        b_all = vb[idx];
        mask_all = vm[idx];
      end
      step();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_sent", idx, 6);
    chk("stall_results", npop - p0, 6);

    // Random traffic on both sides of the handshake
    nacc = 0;
    for (int k = 0; k < 40000 && nacc < 10000; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a_all = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      b_all = ($urandom_range(0, 7) == 0) ? 36'h8_0402_0100 : 36'({$urandom(), $urandom()});
      mask_all = 4'($urandom());
      step();
      if (accepted) nacc++;
    end
    chk("random_accepted", nacc, 10000);
    drain();

    // Reset with three results in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_all = $urandom();
      b_all = 36'({$urandom(), $urandom()});
      mask_all = 4'($urandom());
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    for (int c = 0; c < NCFG; c++) hold[c] = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = npop;
    repeat (6) step();
    chk("no_stale", npop - p0, 0);
    run_single(pa(7, 8, 9, 0), pb(-3, 4, 5, 0), 4'b0010);
    chk("post_reset y0", ly[0], -8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
